// File: rtl/maxpool_window_reader_pkg.sv
// Shared definitions for the maxpool window reader: window-position codes,
// controller states and the per-pixel tag that travels with the data.
package maxpool_window_reader_pkg;

    localparam logic [1:0] WIN_TL = 2'd0;
    localparam logic [1:0] WIN_TR = 2'd1;
    localparam logic [1:0] WIN_BL = 2'd2;
    localparam logic [1:0] WIN_BR = 2'd3;

    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0] win_pos;
        logic       win_last;
        logic       frame_last;
    } win_tag_t;

    // Frame_Last can only ever sit on the BR pixel of the final window.
    function automatic win_tag_t make_tag(input logic [1:0] pos, input logic last_window);
        win_tag_t t;
        t.win_pos    = pos;
        t.win_last   = (pos == WIN_BR);
        t.frame_last = (pos == WIN_BR) & last_window;
        return t;
    endfunction

endpackage

// File: rtl/maxpool_window_reader_if.sv
// Memory read bus and tagged pixel stream of the maxpool window reader.
interface maxpool_window_reader_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    logic                  Rd_En;
    logic [ADDR_WIDTH-1:0] Rd_Addr;
    logic [DATA_WIDTH-1:0] Rd_Data;
    logic                  Out_Valid;
    logic                  Out_Ready;
    logic [DATA_WIDTH-1:0] Out_Data;
    logic [1:0]            Win_Pos;
    logic                  Win_Last;
    logic                  Frame_Last;

    modport master (
        output Rd_En, Rd_Addr, Out_Valid, Out_Data, Win_Pos, Win_Last, Frame_Last,
        input  Rd_Data, Out_Ready
    );

    modport slave (
        input  Rd_En, Rd_Addr, Out_Valid, Out_Data, Win_Pos, Win_Last, Frame_Last,
        output Rd_Data, Out_Ready
    );
endinterface

// File: rtl/maxpool_window_reader_skid_fifo.sv
// Two-entry FIFO holding pixel words (data plus tags) waiting for the consumer.
module pool_skid_fifo #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
endmodule

// File: rtl/maxpool_window_reader.sv
// Reads a row-major feature map and streams it in 2x2 window order with
// window-position tags, throttled by a two-entry FIFO credit scheme.
module maxpool_window_reader
    import maxpool_window_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_Addr,
    input  logic [ADDR_WIDTH-1:0] Img_Width,
    input  logic [ADDR_WIDTH-1:0] Img_Height,
    output logic                  Busy,
    output logic                  Frame_Done,
    maxpool_window_reader_if.master bus
);
    localparam int ENTRY_W = DATA_WIDTH + TAG_W;
    localparam logic [ADDR_WIDTH-1:0] EVEN_MASK = {{(ADDR_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [ADDR_WIDTH-1:0] TWO = ADDR_WIDTH'(2);

    if (RD_LATENCY != 1) begin : g_latency_check
        $error("maxpool_window_reader only supports RD_LATENCY == 1");
    end

    state_e                state_r;
    logic                  rd_en_r, infl_r, busy_r, done_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    win_tag_t              rd_tag_r, infl_tag_r;
    logic [ADDR_WIDTH-1:0] width_r, w2_r, h2_r, col_r, row_r, row_base_r;
    logic [1:0]            pos_r;

    logic [1:0]            fifo_count_s, count_next_s;
    logic [ENTRY_W-1:0]    fifo_head_s, arrive_s, out_entry_s;
    logic                  have_head_s, out_valid_s, accept_s, fifo_push_s, fifo_pop_s;
    logic                  credit_ok_s, last_col_s, last_row_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    win_tag_t              tag_s, out_tag_s;

    pool_skid_fifo #(.WIDTH(ENTRY_W)) u_fifo (
        .clk       (Clk),
        .rst       (Rst),
        .push      (fifo_push_s),
        .push_data (arrive_s),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s)
    );

    // Output stream: the FIFO head has priority; an empty FIFO passes the
    // arriving read straight through so the first pixel costs no extra cycle.
    always_comb begin
        arrive_s    = {bus.Rd_Data, infl_tag_r};
        have_head_s = (fifo_count_s != 2'd0);
        out_valid_s = have_head_s | infl_r;
        if (have_head_s) begin
            out_entry_s = fifo_head_s;
        end else if (infl_r) begin
            out_entry_s = arrive_s;
        end else begin
            out_entry_s = '0;
        end
        accept_s     = out_valid_s & bus.Out_Ready;
        fifo_pop_s   = accept_s & have_head_s;
        fifo_push_s  = infl_r & ~(accept_s & ~have_head_s);
        count_next_s = fifo_count_s + {1'b0, fifo_push_s} - {1'b0, fifo_pop_s};
        // A new read is safe only if its data will still find a free slot
        // when nothing gets popped in between.
        credit_ok_s  = (({1'b0, count_next_s} + {2'b00, rd_en_r}) < 3'd2);
        out_tag_s    = win_tag_t'(out_entry_s[TAG_W-1:0]);
    end

    // Address and tag of the next pixel to read, built from the row-base register.
    always_comb begin
        addr_s     = row_base_r + (pos_r[1] ? width_r : '0) + col_r
                   + {{(ADDR_WIDTH-1){1'b0}}, pos_r[0]};
        last_col_s = ((col_r + TWO) == w2_r);
        last_row_s = ((row_r + TWO) == h2_r);
        tag_s      = make_tag(pos_r, last_col_s & last_row_s);
    end

    // Frame controller with registered read strobe, address and status outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= IDLE;
            rd_en_r    <= 1'b0;
            rd_addr_r  <= '0;
            rd_tag_r   <= '0;
            infl_r     <= 1'b0;
            infl_tag_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            width_r    <= '0;
            w2_r       <= '0;
            h2_r       <= '0;
            col_r      <= '0;
            row_r      <= '0;
            row_base_r <= '0;
            pos_r      <= WIN_TL;
        end else begin
            done_r     <= 1'b0;
            rd_en_r    <= 1'b0;
            infl_r     <= rd_en_r;
            infl_tag_r <= rd_tag_r;
            case (state_r)
                IDLE: begin
                    if (Start && !done_r) begin
                        busy_r     <= 1'b1;
                        width_r    <= Img_Width;
                        w2_r       <= Img_Width & EVEN_MASK;
                        h2_r       <= Img_Height & EVEN_MASK;
                        col_r      <= '0;
                        row_r      <= '0;
                        row_base_r <= Base_Addr;
                        if (((Img_Width & EVEN_MASK) == '0) || ((Img_Height & EVEN_MASK) == '0)) begin
                            state_r <= DONE;
                        end else begin
                            rd_en_r   <= 1'b1;
                            rd_addr_r <= Base_Addr;
                            rd_tag_r  <= make_tag(WIN_TL, 1'b0);
                            pos_r     <= WIN_TR;
                            state_r   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (credit_ok_s) begin
                        rd_en_r   <= 1'b1;
                        rd_addr_r <= addr_s;
                        rd_tag_r  <= tag_s;
                        if (pos_r == WIN_BR) begin
                            pos_r <= WIN_TL;
                            if (last_col_s) begin
                                col_r      <= '0;
                                row_r      <= row_r + TWO;
                                row_base_r <= row_base_r + (width_r << 1);
                                if (last_row_s) begin
                                    state_r <= DRAIN;
                                end
                            end else begin
                                col_r <= col_r + TWO;
                            end
                        end else begin
                            pos_r <= pos_r + 2'd1;
                        end
                    end
                end
                DRAIN: begin
                    if ((count_next_s == 2'd0) && !rd_en_r) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.Rd_En      = rd_en_r;
    assign bus.Rd_Addr    = rd_addr_r;
    assign bus.Out_Valid  = out_valid_s;
    assign bus.Out_Data   = out_entry_s[ENTRY_W-1:TAG_W];
    assign bus.Win_Pos    = out_tag_s.win_pos;
    assign bus.Win_Last   = out_tag_s.win_last;
    assign bus.Frame_Last = out_tag_s.frame_last;
    assign Busy           = busy_r;
    assign Frame_Done     = done_r;
endmodule

// File: tb/tb_maxpool_window_reader.sv
// Randomized bench for maxpool_window_reader: a behavioural window-order model
// predicts every read address and every tagged pixel of each frame.
module tb_maxpool_window_reader;
    import maxpool_window_reader_pkg::*;

    localparam int AW = 14;
    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    pos;
        logic          wlast;
        logic          flast;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] img_width = '0;
    logic [AW-1:0] img_height = '0;
    logic          busy, frame_done;

    maxpool_window_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    maxpool_window_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut (
        .Clk        (clk),
        .Rst        (rst),
        .Start      (start),
        .Base_Addr  (base_addr),
        .Img_Width  (img_width),
        .Img_Height (img_height),
        .Busy       (busy),
        .Frame_Done (frame_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fail_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        if (obs !== expv) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
        end
    endtask

    // Synchronous single-port memory with one cycle of read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (bus.Rd_En) bus.Rd_Data <= mem[bus.Rd_Addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer ready: 0 = always ready, 1 = pattern 1,0,0,1,0,1, else random.
    int         rdy_mode = 0;
    int         rdy_idx = 0;
    logic [5:0] toggle_pat = 6'b101001;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.Out_Ready = 1'b1;
            1: begin
                bus.Out_Ready = toggle_pat[rdy_idx % 6];
                rdy_idx++;
            end
            default: bus.Out_Ready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [AW-1:0] exp_addr_q[$];
    pix_t          exp_pix_q[$];

    bit            mon_en = 1'b0;
    int            issued, accepted, done_cnt, busy_cycles;
    int            first_rd, first_val, first_acc, last_acc, done_cyc, start_cyc;
    bit            prev_stall, prev_busy;
    logic [DW+3:0] prev_word;
    pix_t          px_mon;

    task automatic clear_stats();
        issued = 0; accepted = 0; done_cnt = 0; busy_cycles = 0;
        first_rd = -1; first_val = -1; first_acc = -1; last_acc = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_busy = 1'b0;
    endtask

    // Monitor on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.Rd_En) begin
                check_eq("rd_credit", 32'(issued - accepted < 2), 32'd1);
                if (exp_addr_q.size() == 0) check_eq("rd_extra", 32'd1, 32'd0);
                else check_eq("rd_addr", 32'(bus.Rd_Addr), 32'(exp_addr_q.pop_front()));
                if (first_rd < 0) first_rd = cyc;
                issued++;
            end
            if (bus.Out_Valid && first_val < 0) first_val = cyc;
            if (prev_stall) begin
                check_eq("stall_valid", 32'(bus.Out_Valid), 32'd1);
                check_eq("stall_word", 32'({bus.Out_Data, bus.Win_Pos, bus.Win_Last, bus.Frame_Last}),
                         32'(prev_word));
            end
            if (bus.Out_Valid && bus.Out_Ready) begin
                if (exp_pix_q.size() == 0) begin
                    check_eq("pix_extra", 32'd1, 32'd0);
                end else begin
                    px_mon = exp_pix_q.pop_front();
                    check_eq("pix_data", 32'(bus.Out_Data), 32'(px_mon.data));
                    check_eq("pix_pos", 32'(bus.Win_Pos), 32'(px_mon.pos));
                    check_eq("pix_wlast", 32'(bus.Win_Last), 32'(px_mon.wlast));
                    check_eq("pix_flast", 32'(bus.Frame_Last), 32'(px_mon.flast));
                end
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                accepted++;
            end
            prev_stall = bus.Out_Valid && !bus.Out_Ready;
            prev_word  = {bus.Out_Data, bus.Win_Pos, bus.Win_Last, bus.Frame_Last};
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("busy_fall", 32'({prev_busy, busy}), 32'd2);
            end
            if (busy) busy_cycles++;
            prev_busy = busy;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_rd"}, 32'({bus.Rd_En, bus.Rd_Addr}), 32'd0);
        check_eq({tag, "_out"}, 32'({bus.Out_Valid, bus.Out_Data, bus.Win_Pos, bus.Win_Last, bus.Frame_Last}), 32'd0);
        check_eq({tag, "_stat"}, 32'({busy, frame_done}), 32'd0);
    endtask

    // Expected stream straight from the window-order definition.
    task automatic begin_frame(input logic [AW-1:0] b, input logic [AW-1:0] w, input logic [AW-1:0] h,
                               input int mode, output int total);
        int w2, h2, r, c;
        logic [AW-1:0] a;
        pix_t px;
        w2 = int'(w) & ~1;
        h2 = int'(h) & ~1;
        exp_addr_q.delete();
        exp_pix_q.delete();
        for (int wr = 0; wr < h2 / 2; wr++)
            for (int wc = 0; wc < w2 / 2; wc++)
                for (int p = 0; p < 4; p++) begin
                    r = 2 * wr + p / 2;
                    c = 2 * wc + p % 2;
                    a = AW'(int'(b) + r * int'(w) + c);
                    exp_addr_q.push_back(a);
                    px.data  = mem[a];
                    px.pos   = p[1:0];
                    px.wlast = (p == 3);
                    px.flast = (p == 3) && (wr == h2 / 2 - 1) && (wc == w2 / 2 - 1);
                    exp_pix_q.push_back(px);
                end
        total = exp_pix_q.size();
        clear_stats();
        rdy_mode = mode;
        rdy_idx  = 0;
        mon_en   = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; img_width = w; img_height = h;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = AW'($urandom); img_width = AW'($urandom); img_height = AW'($urandom);
    endtask

    task automatic run_frame(input logic [AW-1:0] b, input logic [AW-1:0] w, input logic [AW-1:0] h,
                             input int mode, input bit mid_start);
        int total, n;
        begin_frame(b, w, h, mode, total);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if (mid_start && n == 6) begin
                start = 1'b1; base_addr = b + AW'(37); img_width = w + AW'(2);
            end else begin
                start = 1'b0;
            end
        end
        check_eq("frame_timeout", 32'(n < 3000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("done_once", 32'(done_cnt), 32'd1);
        check_eq("addr_left", 32'(exp_addr_q.size()), 32'd0);
        check_eq("pix_count", 32'(accepted), 32'(total));
        if (total > 0) begin
            check_eq("rd_latency", 32'(first_rd - start_cyc), 32'd1);
            check_eq("val_latency", 32'(first_val - start_cyc), 32'd2);
            if (mode == 0) check_eq("back_to_back", 32'(last_acc - first_acc), 32'(total - 1));
        end else begin
            check_eq("empty_reads", 32'(issued), 32'd0);
            check_eq("empty_done_cyc", 32'(done_cyc - start_cyc), 32'd2);
            check_eq("empty_busy", 32'(busy_cycles), 32'd1);
        end
    endtask

    initial begin
        int total, n;
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        run_frame(14'd100, 14'd4, 14'd4, 0, 1'b0);
        run_frame(14'd0,   14'd5, 14'd3, 0, 1'b0);
        run_frame(14'd7,   14'd1, 14'd8, 0, 1'b0);
        run_frame(14'd20,  14'd4, 14'd2, 1, 1'b0);
        run_frame(14'd300, 14'd8, 14'd8, 2, 1'b1);

        // Abort an 8x8 frame while its 6th pixel is on the output.
        begin_frame(14'd500, 14'd8, 14'd8, 0, total);
        n = 0;
        while (accepted < 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("abort_reach", 32'(accepted), 32'd5);
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_outputs_zero("abort");
        exp_addr_q.delete();
        exp_pix_q.delete();
        clear_stats();
        mon_en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        check_eq("abort_no_rd", 32'(issued), 32'd0);
        run_frame(14'd500, 14'd8, 14'd8, 2, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_frame((k == 0) ? 14'd16380 : AW'($urandom_range(0, (1 << AW) - 1)),
                      AW'($urandom_range(0, 9)), AW'($urandom_range(0, 9)), 2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule
